// File: rtl/arp_note_sequencer.sv
// Arpeggio note sequencer and sine-table address generator on a single clock.
// A note register scales the base sample divisor; a sample counter steps the table address.
module arp_note_sequencer #(
  parameter int ADDR_BITS  = 8,
  parameter int DIV_BITS   = 12,
  parameter int NOTE_TICKS = 50000000
) (
  input  logic                 CLK100MHZ,
  input  logic                 RESET,
  input  logic [DIV_BITS-1:0]  base_div,
  input  logic                 arp_en,
  input  logic [1:0]           mode,
  output logic [ADDR_BITS-1:0] addra,
  output logic                 addr_step,
  output logic [1:0]           note,
  output logic                 note_start,
  output logic [DIV_BITS:0]    active_div
);

  localparam int CNT_BITS = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_TICK = CNT_BITS'(NOTE_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t                dir, next_dir, step_dir;
  logic [1:0]          next_note;
  logic [CNT_BITS-1:0] note_cnt, next_cnt;
  logic                next_start;
  logic                arp_q;
  mode_t               mode_sel;

  logic [DIV_BITS+1:0] base_ext;
  logic [DIV_BITS+1:0] scaled_div;
  logic [DIV_BITS:0]   div_cnt;
  logic                sample_wrap;

  assign mode_sel = mode_t'(mode);

  // Note sequencing state register.
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      note       <= 2'd0;
      note_cnt   <= '0;
      dir        <= DIR_UP;
      note_start <= 1'b0;
      arp_q      <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      note       <= next_note;
      note_cnt   <= next_cnt;
      dir        <= next_dir;
      note_start <= next_start;
      arp_q      <= arp_en;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_note  = note;
    next_dir   = dir;
    next_cnt   = note_cnt + 1'b1;
    next_start = 1'b0;
    step_dir   = dir;

    if (!arp_en) begin
      next_note = 2'd0;
      next_cnt  = '0;
      next_dir  = DIR_UP;
    end else if (!arp_q) begin
      // First enabled cycle loads the pattern's starting note.
      next_note  = (mode_sel == MODE_DOWN) ? 2'd3 : 2'd0;
      next_cnt   = '0;
      next_dir   = DIR_UP;
      next_start = (next_note != note);
    end else if (note_cnt == LAST_TICK) begin
      next_cnt = '0;
      case (mode_sel)
        MODE_UP:   next_note = note + 2'd1;
        MODE_DOWN: next_note = note - 2'd1;
        MODE_UPDOWN: begin
          if (note == 2'd3)      step_dir = DIR_DOWN;
          else if (note == 2'd0) step_dir = DIR_UP;
          next_dir  = step_dir;
          next_note = (step_dir == DIR_UP) ? note + 2'd1 : note - 2'd1;
        end
        default:   next_note = 2'd0;
      endcase
      next_start = (next_note != note);
    end
  end

  // Divisor scaling: x5/4 and x3/2 are formed as b + b/4 and b + b/2, exact under floor.
  always_comb begin
    base_ext = (base_div == '0) ? (DIV_BITS+2)'(1) : {2'b00, base_div};
    case (note)
      2'd0:    scaled_div = base_ext;
      2'd1:    scaled_div = base_ext + (base_ext >> 2);
      2'd2:    scaled_div = base_ext + (base_ext >> 1);
      default: scaled_div = base_ext << 1;
    endcase
  end

  // The >= compare lets a shrinking divisor wrap immediately instead of overrunning.
  assign sample_wrap = (div_cnt >= active_div - 1'b1);

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      active_div <= (DIV_BITS+1)'(1);
      div_cnt    <= '0;
      addra      <= '0;
      addr_step  <= 1'b0;
    end else begin
      active_div <= scaled_div[DIV_BITS:0];
      if (sample_wrap) begin
        div_cnt   <= '0;
        addra     <= addra + 1'b1;
        addr_step <= 1'b1;
      end else begin
        div_cnt   <= div_cnt + 1'b1;
        addr_step <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arp_note_sequencer.sv
// Directed bench for arp_note_sequencer with NOTE_TICKS=100; outputs sampled 1 time unit after each rising edge.
module tb_arp_note_sequencer;

  localparam int ADDR_BITS  = 8;
  localparam int DIV_BITS   = 12;
  localparam int NOTE_TICKS = 100;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [DIV_BITS-1:0]  base_div = '0;
  logic                 arp_en = 1'b0;
  logic [1:0]           mode = 2'b00;
  logic [ADDR_BITS-1:0] addra;
  logic                 addr_step;
  logic [1:0]           note;
  logic                 note_start;
  logic [DIV_BITS:0]    active_div;

  int checks = 0;
  int errors = 0;

  int exp_seq [0:7];
  int divtab  [0:3];

  arp_note_sequencer #(
    .ADDR_BITS (ADDR_BITS),
    .DIV_BITS  (DIV_BITS),
    .NOTE_TICKS(NOTE_TICKS)
  ) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .base_div  (base_div),
    .arp_en    (arp_en),
    .mode      (mode),
    .addra     (addra),
    .addr_step (addr_step),
    .note      (note),
    .note_start(note_start),
    .active_div(active_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases just after an edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_addra", 32'(addra), 0);
    check("rst_addr_step", 32'(addr_step), 0);
    check("rst_note", 32'(note), 0);
    check("rst_note_start", 32'(note_start), 0);
    check("rst_active_div", 32'(active_div), 1);
    tick();
    rst = 1'b0;
  endtask

  // Steps through an arpeggio run; exp_seq holds the expected note per 100-cycle period.
  task automatic arp_run(input int cycles, input int chg_cycle, input logic [1:0] chg_mode);
    int prev_note = 0;
    for (int c = 1; c <= cycles; c++) begin
      int idx = (c - 1) / NOTE_TICKS;
      int en  = exp_seq[idx];
      int es;
      tick();
      if (c == 1) es = (en != 0) ? 1 : 0;
      else        es = (((c - 1) % NOTE_TICKS) == 0 && en != exp_seq[idx-1]) ? 1 : 0;
      check($sformatf("arp_note_c%0d", c), 32'(note), 32'(en));
      check($sformatf("arp_start_c%0d", c), 32'(note_start), 32'(es));
      check($sformatf("arp_div_c%0d", c), 32'(active_div), 32'(divtab[prev_note]));
      prev_note = en;
      if (c == chg_cycle) mode = chg_mode;
    end
  endtask

  initial begin
    int steps;
    int note_bad;

    divtab = '{8, 10, 12, 16};

    // Root note only, base_div=4: first step right after release, then every 4 cycles.
    base_div = 12'd4; arp_en = 1'b0; mode = 2'b00;
    apply_reset();
    tick();
    check("div4_first_addra", 32'(addra), 1);
    check("div4_first_step", 32'(addr_step), 1);
    check("div4_active_div", 32'(active_div), 4);
    steps = 0; note_bad = 0;
    for (int c = 2; c <= 1021; c++) begin
      tick();
      steps += int'(addr_step);
      if (note != 2'd0) note_bad++;
      if (c == 1017) check("div4_addra_255", 32'(addra), 255);
    end
    check("div4_step_count", 32'(steps), 255);
    check("div4_addra_wrap", 32'(addra), 0);
    check("div4_wrap_step", 32'(addr_step), 1);
    check("div4_note_held", 32'(note_bad), 0);

    // Up pattern, base_div=8.
    base_div = 12'd8; arp_en = 1'b1; mode = 2'b00;
    exp_seq = '{0, 1, 2, 3, 0, 0, 0, 0};
    apply_reset();
    arp_run(450, 0, 2'b00);

    // Disabling returns to the root note on the next edge.
    arp_en = 1'b0;
    tick();
    check("disable_note", 32'(note), 0);
    check("disable_start", 32'(note_start), 0);

    // Up-down pattern.
    arp_en = 1'b1; mode = 2'b10;
    exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
    apply_reset();
    arp_run(750, 0, 2'b00);

    // Down pattern starts at note 3 on the enable cycle.
    mode = 2'b01;
    exp_seq = '{3, 2, 1, 0, 3, 0, 0, 0};
    apply_reset();
    arp_run(450, 0, 2'b00);

    // Hold pattern never leaves the root.
    mode = 2'b11;
    exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
    apply_reset();
    arp_run(250, 0, 2'b00);

    // Mode change mid-note applies only at the next boundary.
    mode = 2'b00;
    exp_seq = '{0, 3, 2, 0, 0, 0, 0, 0};
    apply_reset();
    arp_run(250, 50, 2'b01);

    // Reset mid-note, then the sequence restarts from note 0.
    mode = 2'b00;
    exp_seq = '{0, 1, 2, 3, 0, 0, 0, 0};
    apply_reset();
    arp_run(250, 0, 2'b00);
    check("mid_note_is_2", 32'(note), 2);
    check("mid_addra_nonzero", 32'(addra != '0), 1);
    apply_reset();
    arp_run(150, 0, 2'b00);

    // base_div=0 behaves as 1: address steps every cycle.
    arp_en = 1'b0; base_div = 12'd0;
    apply_reset();
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("div0_addra_c%0d", c), 32'(addra), 32'(c));
      check($sformatf("div0_step_c%0d", c), 32'(addr_step), 1);
      check($sformatf("div0_active_c%0d", c), 32'(active_div), 1);
    end

    // Largest base on note 3 doubles without overflow.
    base_div = 12'd4095; arp_en = 1'b1; mode = 2'b01;
    apply_reset();
    tick();
    check("max_note3", 32'(note), 3);
    check("max_note_start", 32'(note_start), 1);
    tick();
    check("max_active_div", 32'(active_div), 8190);

    // base_div 16 -> 4 while div_cnt=10: the smaller divisor wraps the count immediately.
    base_div = 12'd16; arp_en = 1'b0; mode = 2'b00;
    apply_reset();
    tick();
    check("shrink_first_step", 32'(addr_step), 1);
    steps = 0;
    for (int c = 2; c <= 11; c++) begin
      tick();
      steps += int'(addr_step);
    end
    check("shrink_no_early_step", 32'(steps), 0);
    base_div = 12'd4;
    tick();
    check("shrink_c12_step", 32'(addr_step), 0);
    check("shrink_c12_div", 32'(active_div), 4);
    tick();
    check("shrink_c13_step", 32'(addr_step), 1);
    check("shrink_c13_addra", 32'(addra), 2);
    steps = 0;
    for (int c = 14; c <= 16; c++) begin
      tick();
      steps += int'(addr_step);
    end
    check("shrink_gap", 32'(steps), 0);
    tick();
    check("shrink_c17_step", 32'(addr_step), 1);
    check("shrink_c17_addra", 32'(addra), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
